// File: rtl/time_frame_parser_pkg.sv
// Shared definitions for the time frame parser: FSM encoding, ASCII framing
// bytes, digit count, reset date and small BCD helpers.
package time_frame_parser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DIGITS   = 2'd1,
    ST_WAIT_EOL = 2'd2,
    ST_CHECK    = 2'd3
  } state_t;

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_ZERO   = 8'h30;

  localparam int FRAME_DIGITS = 14;

  localparam logic [15:0] RST_YEAR  = 16'h2000;
  localparam logic [7:0]  RST_MONTH = 8'h01;
  localparam logic [7:0]  RST_DAY   = 8'h01;
  localparam logic [7:0]  RST_HMS   = 8'h00;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CH_ZERO) && (b <= (CH_ZERO + 8'd9));
  endfunction

  // Two packed BCD digits to binary, 0..99.
  function automatic logic [6:0] bcd2bin(input logic [7:0] b);
    return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
  endfunction

endpackage

// File: rtl/time_frame_parser_check.sv
// Combinational calendar validation of 14 captured BCD digits
// (YYYYMMDDhhmmss, most significant digit in the top nibble).
module bcd_date_check
  import time_frame_parser_pkg::*;
(
  input  logic [55:0] digits,
  output logic        ok
);

  logic [7:0] cen, yy, mm, dd, hh, mi, ss;
  logic [6:0] m_bin, d_bin;
  logic [4:0] dim;
  logic       leap;

  assign {cen, yy, mm, dd, hh, mi, ss} = digits;

  // Divisible by 4 from the BCD digits alone; tens parity is bit 4.
  assign leap = yy[4] ? ((yy[3:0] == 4'd2) || (yy[3:0] == 4'd6))
                      : ((yy[3:0] == 4'd0) || (yy[3:0] == 4'd4) || (yy[3:0] == 4'd8));

  always_comb begin
    m_bin = bcd2bin(mm);
    d_bin = bcd2bin(dd);
    case (m_bin)
      7'd4, 7'd6, 7'd9, 7'd11: dim = 5'd30;
      7'd2:                    dim = leap ? 5'd29 : 5'd28;
      default:                 dim = 5'd31;
    endcase
    ok = (cen == 8'h20) &&
         (m_bin >= 7'd1) && (m_bin <= 7'd12) &&
         (d_bin >= 7'd1) && (d_bin <= 7'(dim)) &&
         (bcd2bin(hh) <= 7'd23) &&
         (bcd2bin(mi) <= 7'd59) &&
         (bcd2bin(ss) <= 7'd59);
  end

endmodule

// File: rtl/time_frame_parser.sv
// Parses "$YYYYMMDDhhmmss[CR]LF" frames from a UART byte stream and publishes
// the validated date/time as BCD with a one-cycle time_valid strobe.
module time_frame_parser
  import time_frame_parser_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] year_bcd,
  output logic [7:0]  month_bcd,
  output logic [7:0]  day_bcd,
  output logic [7:0]  hour_bcd,
  output logic [7:0]  minute_bcd,
  output logic [7:0]  second_bcd,
  output logic        time_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state, state_n;
  logic [3:0]    cnt, cnt_n;
  logic          cr_seen, cr_seen_n;
  logic [55:0]   sr, sr_n;
  logic [TW-1:0] tmo, tmo_n;
  logic          tv_n, fe_n;
  logic          date_ok;
  logic          tmo_last;

  bcd_date_check u_check (
    .digits (sr),
    .ok     (date_ok)
  );

  assign busy     = (state != ST_IDLE);
  assign tmo_last = (tmo == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      cr_seen    <= 1'b0;
      sr         <= '0;
      tmo        <= '0;
      time_valid <= 1'b0;
      frame_err  <= 1'b0;
      year_bcd   <= RST_YEAR;
      month_bcd  <= RST_MONTH;
      day_bcd    <= RST_DAY;
      hour_bcd   <= RST_HMS;
      minute_bcd <= RST_HMS;
      second_bcd <= RST_HMS;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      cr_seen    <= cr_seen_n;
      sr         <= sr_n;
      tmo        <= tmo_n;
      time_valid <= tv_n;
      frame_err  <= fe_n;
      if (tv_n)
        {year_bcd, month_bcd, day_bcd, hour_bcd, minute_bcd, second_bcd} <= sr;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    cr_seen_n = cr_seen;
    sr_n      = sr;
    tmo_n     = tmo;
    tv_n      = 1'b0;
    fe_n      = 1'b0;
    case (state)
      ST_IDLE: begin
        tmo_n = '0;
        if (rx_valid && rx_data == CH_DOLLAR) begin
          state_n   = ST_DIGITS;
          cnt_n     = '0;
          cr_seen_n = 1'b0;
        end
      end
      ST_DIGITS, ST_WAIT_EOL: begin
        if (rx_valid) begin
          tmo_n = '0;
          if (rx_data == CH_DOLLAR) begin
            state_n   = ST_DIGITS;
            cnt_n     = '0;
            cr_seen_n = 1'b0;
          end else if (state == ST_DIGITS) begin
            if (is_digit(rx_data)) begin
              sr_n  = {sr[51:0], rx_data[3:0]};
              cnt_n = cnt + 4'd1;
              if (cnt == 4'(FRAME_DIGITS - 1))
                state_n = ST_WAIT_EOL;
            end else begin
              fe_n    = 1'b1;
              state_n = ST_IDLE;
            end
          end else if (rx_data == CH_CR && !cr_seen) begin
            cr_seen_n = 1'b1;
          end else if (rx_data == CH_LF) begin
            state_n = ST_CHECK;
          end else begin
            fe_n    = 1'b1;
            state_n = ST_IDLE;
          end
        end else if (tmo_last) begin
          fe_n    = 1'b1;
          state_n = ST_IDLE;
          tmo_n   = '0;
        end else begin
          tmo_n = tmo + TW'(1);
        end
      end
      ST_CHECK: begin
        // Any byte arriving here is dropped; the frame is already complete.
        tv_n    = date_ok;
        fe_n    = !date_ok;
        tmo_n   = '0;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_time_frame_parser.sv
// Directed bench for time_frame_parser: a byte-level behavioural model predicts
// every output each cycle, and literal expectations pin the key scenarios.
module tb_time_frame_parser;

  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] year_bcd;
  logic [7:0]  month_bcd, day_bcd, hour_bcd, minute_bcd, second_bcd;
  logic        time_valid, frame_err, busy;

  time_frame_parser #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .year_bcd   (year_bcd),
    .month_bcd  (month_bcd),
    .day_bcd    (day_bcd),
    .hour_bcd   (hour_bcd),
    .minute_bcd (minute_bcd),
    .second_bcd (second_bcd),
    .time_valid (time_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural model ----------------
  logic [15:0] exp_year = 16'h2000;
  logic [7:0]  exp_month = 8'h01, exp_day = 8'h01, exp_hour = 8'h00,
               exp_min = 8'h00, exp_sec = 8'h00;
  logic        exp_tv = 1'b0, exp_fe = 1'b0, exp_busy = 1'b0;
  bit          m_in_frame = 0, m_cr = 0, m_pend = 0;
  int          m_n = 0, m_idle = 0;
  logic [3:0]  d [14];

  function automatic bit model_ok(int y, int m, int dd, int h, int mi, int s);
    int dim;
    if (m == 2) dim = (y % 4 == 0) ? 29 : 28;
    else if (m == 4 || m == 6 || m == 9 || m == 11) dim = 30;
    else dim = 31;
    return y >= 2000 && y <= 2099 && m >= 1 && m <= 12 && dd >= 1 && dd <= dim &&
           h <= 23 && mi <= 59 && s <= 59;
  endfunction

  function automatic int two(logic [3:0] a, logic [3:0] b);
    return int'(a) * 10 + int'(b);
  endfunction

  always @(posedge clk) begin
    exp_tv = 1'b0;
    exp_fe = 1'b0;
    if (reset) begin
      m_in_frame = 0; m_pend = 0; m_idle = 0; m_cr = 0; m_n = 0;
      exp_year = 16'h2000; exp_month = 8'h01; exp_day = 8'h01;
      exp_hour = 8'h00; exp_min = 8'h00; exp_sec = 8'h00;
    end else if (m_pend) begin
      m_pend = 0; m_in_frame = 0; m_idle = 0;
      if (model_ok(two(d[0], d[1]) * 100 + two(d[2], d[3]), two(d[4], d[5]),
                   two(d[6], d[7]), two(d[8], d[9]), two(d[10], d[11]), two(d[12], d[13]))) begin
        exp_year  = {d[0], d[1], d[2], d[3]};
        exp_month = {d[4], d[5]};
        exp_day   = {d[6], d[7]};
        exp_hour  = {d[8], d[9]};
        exp_min   = {d[10], d[11]};
        exp_sec   = {d[12], d[13]};
        exp_tv    = 1'b1;
      end else begin
        exp_fe = 1'b1;
      end
    end else if (rx_valid) begin
      m_idle = 0;
      if (rx_data == 8'h24) begin
        m_in_frame = 1; m_n = 0; m_cr = 0;
      end else if (m_in_frame) begin
        if (m_n < 14) begin
          if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            d[m_n] = rx_data[3:0];
            m_n++;
          end else begin
            exp_fe = 1'b1; m_in_frame = 0;
          end
        end else if (rx_data == 8'h0D && !m_cr) m_cr = 1;
        else if (rx_data == 8'h0A) m_pend = 1;
        else begin
          exp_fe = 1'b1; m_in_frame = 0;
        end
      end
    end else if (m_in_frame) begin
      m_idle++;
      if (m_idle == TMO) begin
        exp_fe = 1'b1; m_in_frame = 0; m_idle = 0;
      end
    end
    exp_busy = m_in_frame || m_pend;
  end

  // ---------------- checking ----------------
  int checks = 0, failures = 0;
  int tv_cnt = 0, fe_cnt = 0, tv_cyc = -1, fe_cyc = -1, last_byte_cyc = 0;
  bit cmp_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cmp_cycle();
    chk("time_valid", 32'(time_valid), 32'(exp_tv));
    chk("frame_err", 32'(frame_err), 32'(exp_fe));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("year_bcd", 32'(year_bcd), 32'(exp_year));
    chk("month_bcd", 32'(month_bcd), 32'(exp_month));
    chk("day_bcd", 32'(day_bcd), 32'(exp_day));
    chk("hour_bcd", 32'(hour_bcd), 32'(exp_hour));
    chk("minute_bcd", 32'(minute_bcd), 32'(exp_min));
    chk("second_bcd", 32'(second_bcd), 32'(exp_sec));
    chk("tv_fe_exclusive", 32'(time_valid & frame_err), 32'd0);
    if (time_valid === 1'b1) begin tv_cnt++; tv_cyc = cyc; end
    if (frame_err === 1'b1) begin fe_cnt++; fe_cyc = cyc; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    last_byte_cyc = cyc;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic chk_date(input string nm, input logic [15:0] y, input logic [7:0] mo,
                          input logic [7:0] dd, input logic [7:0] h, input logic [7:0] mi,
                          input logic [7:0] s);
    chk({nm, "_year"}, 32'(year_bcd), 32'(y));
    chk({nm, "_month"}, 32'(month_bcd), 32'(mo));
    chk({nm, "_day"}, 32'(day_bcd), 32'(dd));
    chk({nm, "_hour"}, 32'(hour_bcd), 32'(h));
    chk({nm, "_min"}, 32'(minute_bcd), 32'(mi));
    chk({nm, "_sec"}, 32'(second_bcd), 32'(s));
  endtask

  string tbl [10] = '{"$21000101000000\n", "$20240431000000\n", "$20240430235959\n",
                      "$20240101240000\n", "$20240101000000\r\r\n", "$20000229000000\n",
                      "$20241301000000\n", "$20240100000000\n", "$20960229000000\r\n",
                      "$20240101006000\n"};
  bit tbl_ok [10] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0};

  initial begin
    int t0, f0, tb0;
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    fork
      forever begin
        @(negedge clk);
        if (cmp_en) cmp_cycle();
      end
    join_none
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cmp_en = 1;

    // reset state
    chk_date("rst", 16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00);
    chk("rst_busy", 32'(busy), 32'd0);

    // leap-day frame
    t0 = tv_cnt;
    send_str("$20240229123456\n");
    chk("leap_tv_count", 32'(tv_cnt - t0), 32'd1);
    chk("leap_latency", 32'(tv_cyc - last_byte_cyc), 32'd2);
    chk_date("leap", 16'h2024, 8'h02, 8'h29, 8'h12, 8'h34, 8'h56);

    // non-leap Feb 29 with CR, rejected
    t0 = tv_cnt; f0 = fe_cnt;
    send_str("$20230229000000\r\n");
    chk("feb29_fe_count", 32'(fe_cnt - f0), 32'd1);
    chk("feb29_tv_count", 32'(tv_cnt - t0), 32'd0);
    chk("feb29_latency", 32'(fe_cyc - last_byte_cyc), 32'd2);
    chk_date("feb29_hold", 16'h2024, 8'h02, 8'h29, 8'h12, 8'h34, 8'h56);

    // restart on '$' mid-frame
    t0 = tv_cnt; f0 = fe_cnt;
    send_str("$2024$20241231235959\n");
    chk("restart_tv_count", 32'(tv_cnt - t0), 32'd1);
    chk("restart_fe_count", 32'(fe_cnt - f0), 32'd0);
    chk_date("restart", 16'h2024, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59);

    // non-digit abort, then recovery
    f0 = fe_cnt;
    send_str("$20241A");
    chk("abort_fe_count", 32'(fe_cnt - f0), 32'd1);
    chk("abort_latency", 32'(fe_cyc - last_byte_cyc), 32'd1);
    send_str("$20000101000000\n");
    chk("recover_latency", 32'(tv_cyc - last_byte_cyc), 32'd2);
    chk_date("recover", 16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00);

    // calendar boundaries
    for (int i = 0; i < 10; i++) begin
      t0 = tv_cnt; f0 = fe_cnt;
      send_str(tbl[i]);
      chk($sformatf("tbl%0d_tv", i), 32'(tv_cnt - t0), 32'(tbl_ok[i]));
      chk($sformatf("tbl%0d_fe", i), 32'(fe_cnt - f0), 32'(!tbl_ok[i]));
    end

    // inactivity timeout: pulse follows the 100th idle cycle after the last byte
    f0 = fe_cnt;
    send_str("$2024");
    tb0 = last_byte_cyc;
    repeat (110) @(negedge clk);
    chk("tmo_fe_count", 32'(fe_cnt - f0), 32'd1);
    chk("tmo_latency", 32'(fe_cyc - tb0), 32'(TMO + 1));
    chk("tmo_busy", 32'(busy), 32'd0);

    // reset mid-frame discards it silently
    t0 = tv_cnt; f0 = fe_cnt;
    send_str("$2024010");
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid_tv_count", 32'(tv_cnt - t0), 32'd0);
    chk("rstmid_fe_count", 32'(fe_cnt - f0), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk_date("rstmid", 16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00);
    send_str("$20250315081500\n");
    chk("after_rst_tv_count", 32'(tv_cnt - t0), 32'd1);
    chk("after_rst_fe_count", 32'(fe_cnt - f0), 32'd0);
    chk_date("after_rst", 16'h2025, 8'h03, 8'h15, 8'h08, 8'h15, 8'h00);

    repeat (5) @(negedge clk);
    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/time_frame_parser.md
TIME_FRAME_PARSER -- requirements
Module: time_frame_parser

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100_000_000: maximum idle cycles between bytes inside a frame.
REQ-002 clk  in  1  single clock, all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 rx_data  in  8  received UART byte, valid only with rx_valid.
REQ-005 rx_valid  in  1  one-cycle strobe per received byte.
REQ-006 year_bcd  out  16; month_bcd, day_bcd, hour_bcd, minute_bcd, second_bcd  out  8 each: last accepted time, BCD.
REQ-007 time_valid  out  1  one-cycle pulse, BCD outputs updated this cycle.
REQ-008 frame_err  out  1  one-cycle pulse on a rejected frame.
REQ-009 busy  out  1  high while a frame is in progress (any state except IDLE).

Function
REQ-010 Frame format SHALL be '$' (0x24), 14 ASCII digits YYYYMMDDhhmmss (0x30-0x39), optional CR (0x0D), then LF (0x0A).
REQ-011 FSM states: IDLE, DIGITS, WAIT_EOL, CHECK.
REQ-012 IDLE: '$' -> DIGITS with digit count cleared; all other bytes ignored, no error.
REQ-013 DIGITS: each digit byte shifts its low nibble into a 56-bit shift register and increments the count (0..14); the 14th digit -> WAIT_EOL.
REQ-014 DIGITS: '$' SHALL restart the frame (count cleared, stay DIGITS, no error); any other non-digit -> frame_err pulse, IDLE.
REQ-015 WAIT_EOL: CR ignored (at most one; a second CR is an error); LF -> CHECK; '$' restarts as REQ-014; other bytes -> frame_err, IDLE.
REQ-016 CHECK (one cycle, no byte consumed): validate year 2000-2099, month 01-12, day 01..days_in_month, hour <= 23, minute <= 59, second <= 59.
REQ-017 days_in_month: 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; February 29 if leap, else 28.
REQ-018 Leap if year BCD low two digits divisible by 4 (tens even with ones in {0,4,8}, or tens odd with ones in {2,6}); 2000 is leap.
REQ-019 Latency: LF accepted at cycle N -> CHECK at N+1 -> on pass, all six outputs updated together and time_valid high at N+2; on fail, frame_err high at N+2, outputs unchanged; both -> IDLE.
REQ-020 Outputs SHALL hold their last accepted value between frames; a partial or rejected frame SHALL never alter them.
REQ-021 Timeout counter clears on every rx_valid and counts in DIGITS/WAIT_EOL; reaching TIMEOUT_CYCLES -> frame_err pulse, IDLE.
REQ-022 rx_valid during CHECK SHALL be dropped (at most one per frame; UART byte spacing exceeds 2 cycles).
REQ-023 time_valid and frame_err SHALL never be high in the same cycle and SHALL be one cycle wide.

Reset
REQ-024 While reset is high at a clock edge: state IDLE, count 0, timeout counter 0, shift register 0.
REQ-025 Reset outputs: year_bcd 16'h2000, month_bcd 8'h01, day_bcd 8'h01, hour/minute/second_bcd 8'h00, time_valid 0, frame_err 0, busy 0.
REQ-026 Reset mid-frame SHALL discard the frame with no pulse on time_valid or frame_err.

Structure
REQ-027 Shared package holds: state encoding, ASCII constants ('$', CR, LF, '0'), frame digit count 14, reset BCD date constants.
REQ-028 One sub-module, bcd_date_check: combinational range/leap check of the 14 captured BCD digits, output ok.

Verification
REQ-029 "$20240229123456\n" -> time_valid at LF+2, outputs 2024/02/29 12:34:56.
REQ-030 "$20230229000000\r\n" -> frame_err at LF+2, outputs keep previous values, no time_valid.
REQ-031 "$2024$20241231235959\n" -> single time_valid, outputs 2024/12/31 23:59:59, no frame_err.
REQ-032 "$20241A..." -> frame_err the cycle after 'A'; then "$20000101000000\n" accepted.
REQ-033 "$2024" then silence, TIMEOUT_CYCLES=100 -> frame_err 100 cycles after last byte, busy falls.
REQ-034 Reset asserted after 7 digits, then full valid frame -> no pulse from the aborted frame, new frame accepted normally.
